// File: rtl/l2_fwd_stall_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : l2_fwd_stall_tracker
//  Purpose  : Holds a single forwarded request that the L2 could not service
//             because its line has an MSHR in a transient state. Tells the L2
//             input decoder when a fwd is held (fwd_stall) and when it may be
//             replayed (fwd_stall_ended), and presents the held address and
//             payload for the replay.
//  Config   : L2_FWD_STALL_WDOG_EN - when defined, a watchdog counts cycles
//             spent waiting on the MSHR and raises a sticky wdog_expired after
//             WDOG_LIMIT cycles. When undefined, wdog_expired is tied low.
//  Ports    :
//    clk                     in  clock
//    rst                     in  asynchronous reset, active-low
//    set_fwd_stall           in  capture the current fwd and start stalling
//    fwd_cap_addr            in  line address of the fwd being captured
//    fwd_cap_payload         in  payload of the fwd being captured
//    fwd_cap_mshr_i          in  MSHR entry the captured fwd waits on
//    mshr_clr_valid          in  an MSHR entry retired this cycle
//    mshr_clr_i              in  index of the retired MSHR entry
//    set_fwd_in_from_stalled in  decoder consumed the held fwd
//    fwd_stall               out a fwd is held (waiting or ready)
//    fwd_stall_ended         out the held fwd is ready to replay
//    stalled_addr            out held line address
//    stalled_payload         out held payload
//    proto_err               out sticky: illegal handshake observed
//    wdog_expired            out sticky: watchdog tripped
//  Revision : 1.0 - initial release
// ============================================================================
module l2_fwd_stall_tracker #(
  parameter int LINE_ADDR_W = 26,
  parameter int PAYLOAD_W   = 40,
  parameter int MSHR_IDX_W  = 2,
  parameter int WDOG_LIMIT  = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_fwd_stall,
  input  logic [LINE_ADDR_W-1:0] fwd_cap_addr,
  input  logic [PAYLOAD_W-1:0]   fwd_cap_payload,
  input  logic [MSHR_IDX_W-1:0]  fwd_cap_mshr_i,
  input  logic                   mshr_clr_valid,
  input  logic [MSHR_IDX_W-1:0]  mshr_clr_i,
  input  logic                   set_fwd_in_from_stalled,
  output logic                   fwd_stall,
  output logic                   fwd_stall_ended,
  output logic [LINE_ADDR_W-1:0] stalled_addr,
  output logic [PAYLOAD_W-1:0]   stalled_payload,
  output logic                   proto_err,
  output logic                   wdog_expired
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALLED = 2'd1,
    ST_ENDED   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [MSHR_IDX_W-1:0]  mshr_q, mshr_d;
  logic                   proto_err_q, proto_err_d;

  // Elaboration-time sanity check on the watchdog limit.
  if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
    $error("l2_fwd_stall_tracker: WDOG_LIMIT must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    payload_d   = payload_q;
    mshr_d      = mshr_q;
    proto_err_d = proto_err_q;

    // Illegal handshakes only flag the error; they never disturb the held fwd.
    if (set_fwd_stall && (state_q != ST_IDLE)) begin
      proto_err_d = 1'b1;
    end
    if (set_fwd_in_from_stalled && (state_q != ST_ENDED)) begin
      proto_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (set_fwd_stall) begin
          addr_d    = fwd_cap_addr;
          payload_d = fwd_cap_payload;
          mshr_d    = fwd_cap_mshr_i;
          // The awaited MSHR may retire in the very cycle the fwd is stalled;
          // compare against the incoming index since mshr_q is not yet loaded.
          if (mshr_clr_valid && (mshr_clr_i == fwd_cap_mshr_i)) begin
            state_d = ST_ENDED;
          end else begin
            state_d = ST_STALLED;
          end
        end
      end
      ST_STALLED: begin
        if (mshr_clr_valid && (mshr_clr_i == mshr_q)) begin
          state_d = ST_ENDED;
        end
      end
      ST_ENDED: begin
        // Held regs are intentionally left intact on replay.
        if (set_fwd_in_from_stalled) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      payload_q   <= '0;
      mshr_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      payload_q   <= payload_d;
      mshr_q      <= mshr_d;
      proto_err_q <= proto_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef L2_FWD_STALL_WDOG_EN
  localparam int                    WDOG_CNT_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_CNT_W-1:0] WDOG_MAX   = WDOG_CNT_W'(WDOG_LIMIT);

  logic [WDOG_CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic [WDOG_CNT_W-1:0] wdog_cnt_inc;
  logic                  wdog_expired_q, wdog_expired_d;

  always_comb begin
    wdog_cnt_d     = '0;
    wdog_expired_d = wdog_expired_q;
    wdog_cnt_inc   = (wdog_cnt_q == WDOG_MAX) ? WDOG_MAX : (wdog_cnt_q + 1'b1);

    // wdog_cnt_inc is the number of STALLED cycles including this one, so
    // the flag rises at the end of the WDOG_LIMIT-th waiting cycle even if
    // that cycle is also the one leaving STALLED.
    if (state_q == ST_STALLED) begin
      if (wdog_cnt_inc == WDOG_MAX) begin
        wdog_expired_d = 1'b1;
      end
      if (state_d == ST_STALLED) begin
        wdog_cnt_d = wdog_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q     <= '0;
      wdog_expired_q <= 1'b0;
    end else begin
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_expired_q <= wdog_expired_d;
    end
  end

  assign wdog_expired = wdog_expired_q;
`else
  assign wdog_expired = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs: decoded from state or straight from flops
  // --------------------------------------------------------------------------
  assign fwd_stall       = (state_q != ST_IDLE);
  assign fwd_stall_ended = (state_q == ST_ENDED);
  assign stalled_addr    = addr_q;
  assign stalled_payload = payload_q;
  assign proto_err       = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_fwd_stall_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_fwd_stall_tracker
//  Purpose  : Self-checking bench for l2_fwd_stall_tracker. Directed cases
//             with literal expectations, then randomized traffic compared
//             every cycle against a behavioural model of the held fwd.
//  Config   : honours L2_FWD_STALL_WDOG_EN for the watchdog expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l2_fwd_stall_tracker;

  localparam int AW = 26;
  localparam int PW = 40;
  localparam int MW = 2;
  localparam int WL = 16;

`ifdef L2_FWD_STALL_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          set_fwd_stall;
  logic [AW-1:0] fwd_cap_addr;
  logic [PW-1:0] fwd_cap_payload;
  logic [MW-1:0] fwd_cap_mshr_i;
  logic          mshr_clr_valid;
  logic [MW-1:0] mshr_clr_i;
  logic          set_fwd_in_from_stalled;
  logic          fwd_stall;
  logic          fwd_stall_ended;
  logic [AW-1:0] stalled_addr;
  logic [PW-1:0] stalled_payload;
  logic          proto_err;
  logic          wdog_expired;

  always #5 clk = ~clk;

  l2_fwd_stall_tracker #(
    .LINE_ADDR_W (AW),
    .PAYLOAD_W   (PW),
    .MSHR_IDX_W  (MW),
    .WDOG_LIMIT  (WL)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .set_fwd_stall           (set_fwd_stall),
    .fwd_cap_addr            (fwd_cap_addr),
    .fwd_cap_payload         (fwd_cap_payload),
    .fwd_cap_mshr_i          (fwd_cap_mshr_i),
    .mshr_clr_valid          (mshr_clr_valid),
    .mshr_clr_i              (mshr_clr_i),
    .set_fwd_in_from_stalled (set_fwd_in_from_stalled),
    .fwd_stall               (fwd_stall),
    .fwd_stall_ended         (fwd_stall_ended),
    .stalled_addr            (stalled_addr),
    .stalled_payload         (stalled_payload),
    .proto_err               (proto_err),
    .wdog_expired            (wdog_expired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: "is something held" and "has its MSHR retired".
  bit            m_hold;
  bit            m_done;
  bit            m_err;
  bit            m_wdog;
  int            m_run;      // consecutive cycles spent waiting on the MSHR
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_payload;
  logic [MW-1:0] m_mshr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_done = 0; m_err = 0; m_wdog = 0; m_run = 0;
    m_addr = '0; m_payload = '0; m_mshr = '0;
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_step();
    if (rst) begin
      if (m_hold && !m_done) begin
        m_run++;
        if (m_run >= WL) m_wdog = 1;
      end else begin
        m_run = 0;
      end
      if (set_fwd_stall && m_hold) m_err = 1;
      if (set_fwd_in_from_stalled && !(m_hold && m_done)) m_err = 1;
      if (!m_hold) begin
        if (set_fwd_stall) begin
          m_addr    = fwd_cap_addr;
          m_payload = fwd_cap_payload;
          m_mshr    = fwd_cap_mshr_i;
          m_hold    = 1;
          m_done    = mshr_clr_valid && (mshr_clr_i == fwd_cap_mshr_i);
        end
      end else if (!m_done) begin
        if (mshr_clr_valid && (mshr_clr_i == m_mshr)) m_done = 1;
      end else if (set_fwd_in_from_stalled) begin
        m_hold = 0;
        m_done = 0;
      end
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("fwd_stall", 64'(fwd_stall), 64'(m_hold));
    check("fwd_stall_ended", 64'(fwd_stall_ended), 64'(m_hold && m_done));
    check("proto_err", 64'(proto_err), 64'(m_err));
    check("wdog_expired", 64'(wdog_expired), 64'(WDOG_ON && m_wdog));
    if (m_hold) begin
      check("stalled_addr", 64'(stalled_addr), 64'(m_addr));
      check("stalled_payload", 64'(stalled_payload), 64'(m_payload));
    end
  end

  task automatic idle_inputs();
    set_fwd_stall = 0; set_fwd_in_from_stalled = 0; mshr_clr_valid = 0;
    fwd_cap_addr = '0; fwd_cap_payload = '0; fwd_cap_mshr_i = '0; mshr_clr_i = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
  endtask

  task automatic do_stall(input logic [AW-1:0] a, input logic [PW-1:0] p, input logic [MW-1:0] m);
    set_fwd_stall = 1; fwd_cap_addr = a; fwd_cap_payload = p; fwd_cap_mshr_i = m;
  endtask

  task automatic do_clr(input logic [MW-1:0] m);
    mshr_clr_valid = 1; mshr_clr_i = m;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    model_reset();
    #2;
    check("reset fwd_stall", 64'(fwd_stall), 64'd0);
    check("reset ended", 64'(fwd_stall_ended), 64'd0);
    check("reset addr", 64'(stalled_addr), 64'd0);
    check("reset proto_err", 64'(proto_err), 64'd0);
    check("reset wdog", 64'(wdog_expired), 64'd0);
    cycle(); cycle();
    rst = 1;

    // Basic stall
    do_stall(26'h1A2B, 40'h12_3456_789A, 2'd2); cycle();
    check("basic stall", 64'(fwd_stall), 64'd1);
    check("basic ended0", 64'(fwd_stall_ended), 64'd0);
    check("basic addr", 64'(stalled_addr), 64'h1A2B);
    check("basic payload", 64'(stalled_payload), 64'h12_3456_789A);
    do_clr(2'd2); cycle();
    check("basic ended1", 64'(fwd_stall_ended), 64'd1);
    set_fwd_in_from_stalled = 1; cycle();
    check("basic release stall", 64'(fwd_stall), 64'd0);
    check("basic release ended", 64'(fwd_stall_ended), 64'd0);
    check("basic no err", 64'(proto_err), 64'd0);
    check("basic addr kept", 64'(stalled_addr), 64'h1A2B);

    // Wrong index
    do_stall(26'h0333, 40'h0, 2'd1); cycle();
    do_clr(2'd0); cycle();
    check("wrong idx0", 64'({fwd_stall, fwd_stall_ended}), 64'b10);
    do_clr(2'd3); cycle();
    check("wrong idx3", 64'({fwd_stall, fwd_stall_ended}), 64'b10);
    do_clr(2'd1); cycle();
    check("right idx1", 64'({fwd_stall, fwd_stall_ended}), 64'b11);
    set_fwd_in_from_stalled = 1; cycle();

    // Same-cycle capture and clear
    do_stall(26'h0444, 40'hAB, 2'd3); do_clr(2'd3); cycle();
    check("same-cycle", 64'({fwd_stall, fwd_stall_ended}), 64'b11);
    set_fwd_in_from_stalled = 1; cycle();

    // Protocol errors
    do_stall(26'h0055, 40'h55, 2'd0); cycle();
    check("no early wdog", 64'(wdog_expired), 64'd0);
    do_stall(26'h0077, 40'h77, 2'd1); cycle();
    check("dup stall err", 64'(proto_err), 64'd1);
    check("dup stall addr", 64'(stalled_addr), 64'h55);
    set_fwd_in_from_stalled = 1; cycle();
    check("early release err", 64'(proto_err), 64'd1);
    check("early release state", 64'({fwd_stall, fwd_stall_ended}), 64'b10);

    // Watchdog: remain stalled well past WL cycles
    for (int i = 0; i < 20; i++) cycle();
    check("wdog tripped", 64'(wdog_expired), 64'(WDOG_ON));
    do_clr(2'd0); cycle();
    set_fwd_in_from_stalled = 1; cycle();
    check("wdog sticky", 64'(wdog_expired), 64'(WDOG_ON));

    // Asynchronous reset while ENDED
    do_stall(26'h0099, 40'h99, 2'd2); do_clr(2'd2); cycle();
    #2;
    rst = 0;
    model_reset();
    #1;
    check("async rst stall", 64'(fwd_stall), 64'd0);
    check("async rst ended", 64'(fwd_stall_ended), 64'd0);
    check("async rst err", 64'(proto_err), 64'd0);
    check("async rst wdog", 64'(wdog_expired), 64'd0);
    @(posedge clk); #1;
    rst = 1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      set_fwd_stall           = ($urandom_range(0, 99) < (m_hold ? 3 : 30));
      set_fwd_in_from_stalled = (m_hold && m_done) ? ($urandom_range(0, 99) < 40)
                                                   : ($urandom_range(0, 99) < 2);
      mshr_clr_valid          = ($urandom_range(0, 99) < 15);
      mshr_clr_i              = MW'($urandom_range(0, 3));
      fwd_cap_mshr_i          = MW'($urandom_range(0, 3));
      fwd_cap_addr            = AW'($urandom);
      fwd_cap_payload         = PW'({$urandom, $urandom});
      cycle();
      if ($urandom_range(0, 249) == 0) begin
        rst = 0;
        model_reset();
        #2;
        rst = 1;
      end
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
